// File: rtl/quad_step_decoder_if.sv
// Encoder-side bus for quad_step_decoder: raw A/B phases and error clear in,
// step controls and status out.
interface quad_step_decoder_if #(
   parameter int ERR_CNT_W = 8
);
   logic                 a_in;
   logic                 b_in;
   logic                 err_clr;
   logic                 en;
   logic                 dir;
   logic                 err;
   logic [ERR_CNT_W-1:0] err_cnt;
   logic                 ready;

   modport master (
      output a_in, b_in, err_clr,
      input  en, dir, err, err_cnt, ready
   );

   modport slave (
      input  a_in, b_in, err_clr,
      output en, dir, err, err_cnt, ready
   );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: synchronise, de-glitch, track Gray phase and emit
// one registered en pulse per legal step with dir; counts illegal jumps.
module quad_step_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4,
   parameter int ERR_CNT_W   = 8
) (
   input logic                 clk,
   input logic                 rst,
   quad_step_decoder_if.slave  bus
);
   localparam int CW     = $clog2(FILT_LEN + 1);
   localparam int SETTLE = SYNC_STAGES + FILT_LEN + 1;
   localparam int SW     = $clog2(SETTLE + 1);
   localparam logic [CW-1:0] FILT_LAST   = CW'(FILT_LEN - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

   typedef enum logic [2:0] {S_INIT, S_P00, S_P01, S_P11, S_P10} state_t;

   logic [SYNC_STAGES-1:0] r_sync [2];
   logic [CW-1:0]          r_fcnt [2];
   logic [1:0]             r_filt;
   logic [1:0]             w_raw;
   logic [1:0]             w_s;

   state_t               r_state, w_state_nxt;
   logic [SW-1:0]        r_settle, w_settle_nxt;
   logic                 r_en, w_en_nxt;
   logic                 r_dir, w_dir_nxt;
   logic                 r_err, w_err_nxt;
   logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt_nxt;
   logic                 r_ready, w_ready_nxt;
   logic [1:0]           w_cur;

   function automatic state_t phase_to_state(input logic [1:0] p);
      case (p)
         2'b00:   return S_P00;
         2'b01:   return S_P01;
         2'b11:   return S_P11;
         default: return S_P10;
      endcase
   endfunction

   function automatic logic [1:0] state_to_phase(input state_t s);
      case (s)
         S_P01:   return 2'b01;
         S_P11:   return 2'b11;
         S_P10:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] fwd_of(input logic [1:0] p);
      case (p)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] rev_of(input logic [1:0] p);
      case (p)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   // Channel 1 is A, channel 0 is B, so r_filt is the phase {a_f, b_f}.
   always_comb begin
      w_raw = {bus.a_in, bus.b_in};
      w_s   = {r_sync[1][SYNC_STAGES-1], r_sync[0][SYNC_STAGES-1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_filt <= '0;
         for (int unsigned ch = 0; ch < 2; ch++) begin
            r_sync[ch] <= '0;
            r_fcnt[ch] <= '0;
         end
      end else begin
         for (int unsigned ch = 0; ch < 2; ch++) begin
            r_sync[ch] <= {r_sync[ch][SYNC_STAGES-2:0], w_raw[ch]};
            if (w_s[ch] == r_filt[ch]) begin
               r_fcnt[ch] <= '0;
            end else if (r_fcnt[ch] == FILT_LAST) begin
               r_filt[ch] <= w_s[ch];
               r_fcnt[ch] <= '0;
            end else begin
               r_fcnt[ch] <= r_fcnt[ch] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_INIT;
         r_settle  <= '0;
         r_en      <= 1'b0;
         r_dir     <= 1'b0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_settle  <= w_settle_nxt;
         r_en      <= w_en_nxt;
         r_dir     <= w_dir_nxt;
         r_err     <= w_err_nxt;
         r_err_cnt <= w_err_cnt_nxt;
         r_ready   <= w_ready_nxt;
      end
   end

   // A new illegal transition wins over err_clr in the same cycle.
   always_comb begin
      w_state_nxt   = r_state;
      w_settle_nxt  = r_settle;
      w_en_nxt      = 1'b0;
      w_dir_nxt     = r_dir;
      w_err_nxt     = r_err & ~bus.err_clr;
      w_err_cnt_nxt = r_err_cnt;
      w_ready_nxt   = r_ready;
      w_cur         = state_to_phase(r_state);
      if (r_state == S_INIT) begin
         if (r_settle == SETTLE_LAST) begin
            w_state_nxt = phase_to_state(r_filt);
            w_ready_nxt = 1'b1;
         end else begin
            w_settle_nxt = r_settle + 1'b1;
         end
      end else if (r_filt == fwd_of(w_cur)) begin
         w_state_nxt = phase_to_state(r_filt);
         w_en_nxt    = 1'b1;
         w_dir_nxt   = 1'b1;
      end else if (r_filt == rev_of(w_cur)) begin
         w_state_nxt = phase_to_state(r_filt);
         w_en_nxt    = 1'b1;
         w_dir_nxt   = 1'b0;
      end else if (r_filt != w_cur) begin
         w_state_nxt = phase_to_state(r_filt);
         w_err_nxt   = 1'b1;
         if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + 1'b1;
      end
   end

   assign bus.en      = r_en;
   assign bus.dir     = r_dir;
   assign bus.err     = r_err;
   assign bus.err_cnt = r_err_cnt;
   assign bus.ready   = r_ready;
endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: expected en pulses (cycle, dir) are
// queued as phases are driven and matched when en is observed.
module tb_quad_step_decoder;
   localparam int SYNC_STAGES = 2;
   localparam int FILT_LEN    = 4;
   localparam int ERR_CNT_W   = 8;
   localparam int LAT         = SYNC_STAGES + FILT_LEN + 1;

   typedef struct {
      int unsigned cyc;
      logic        dir;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   quad_step_decoder_if #(.ERR_CNT_W(ERR_CNT_W)) qif ();

   quad_step_decoder #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN(FILT_LEN),
      .ERR_CNT_W(ERR_CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(qif)
   );

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   int          ctr      = 0;
   int unsigned merr     = 0;
   logic [1:0]  ph       = 2'b11;
   exp_t        sb [$];

   function automatic logic [1:0] nxt_fwd(input logic [1:0] p);
      case (p)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] nxt_rev(input logic [1:0] p);
      case (p)
         2'b01:   return 2'b00;
         2'b11:   return 2'b01;
         2'b10:   return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      if (sb.size() > 0 && cyc > sb[0].cyc && !qif.en) begin
         e = sb.pop_front();
         chk("en_missing", {31'd0, qif.en}, 32'd1);
      end
      if (qif.en) begin
         if (sb.size() == 0) begin
            chk("en_unexpected", {31'd0, qif.en}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("en_cycle", cyc, e.cyc);
            chk("en_dir", {31'd0, qif.dir}, {31'd0, e.dir});
         end
         ctr += qif.dir ? 1 : -1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      monitor();
   endtask

   task automatic drive(input logic [1:0] nph, input int unsigned hold);
      exp_t e;
      e.cyc = cyc + LAT;
      if (nph == nxt_fwd(ph)) begin
         e.dir = 1'b1;
         sb.push_back(e);
      end else if (nph == nxt_rev(ph)) begin
         e.dir = 1'b0;
         sb.push_back(e);
      end else if (nph != ph) begin
         if (merr < 255) merr++;
      end
      ph = nph;
      qif.a_in = nph[1];
      qif.b_in = nph[0];
      repeat (hold) tick();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_en"},      {31'd0, qif.en},    32'd0);
      chk({tag, "_dir"},     {31'd0, qif.dir},   32'd0);
      chk({tag, "_err"},     {31'd0, qif.err},   32'd0);
      chk({tag, "_err_cnt"}, {24'd0, qif.err_cnt}, 32'd0);
      chk({tag, "_ready"},   {31'd0, qif.ready}, 32'd0);
   endtask

   initial begin
      exp_t g;
      qif.a_in    = 1'b1;
      qif.b_in    = 1'b1;
      qif.err_clr = 1'b0;

      // 1: reset with A=B=1, settle, land in P11
      repeat (3) tick();
      chk_reset_vals("rst1");
      rst = 1'b0;
      repeat (LAT - 1) tick();
      chk("ready_early", {31'd0, qif.ready}, 32'd0);
      tick();
      chk("ready_settled", {31'd0, qif.ready}, 32'd1);
      chk("err_after_init", {31'd0, qif.err}, 32'd0);
      ph = 2'b11;
      repeat (5) tick();
      drive(2'b01, 10);
      drive(2'b00, 10);

      // 2: eight forward steps from P00
      ctr = 0;
      for (int i = 0; i < 8; i++) drive(nxt_fwd(ph), 10);
      chk("fwd_counter", ctr, 32'd8);
      chk("fwd_dir", {31'd0, qif.dir}, 32'd1);

      // 3: three reverse steps
      for (int i = 0; i < 3; i++) drive(nxt_rev(ph), 10);
      chk("rev_counter", ctr, 32'd5);
      repeat (20) tick();
      chk("rev_dir_held", {31'd0, qif.dir}, 32'd0);

      // 4: A glitch of FILT_LEN-1 rejected, FILT_LEN accepted then reversed
      qif.a_in = ~ph[1];
      repeat (FILT_LEN - 1) tick();
      qif.a_in = ph[1];
      repeat (12) tick();
      g.cyc = cyc + LAT; g.dir = 1'b1;
      sb.push_back(g);
      qif.a_in = ~ph[1];
      repeat (FILT_LEN) tick();
      g.cyc = cyc + LAT; g.dir = 1'b0;
      sb.push_back(g);
      qif.a_in = ph[1];
      repeat (12) tick();
      chk("glitch_err", {31'd0, qif.err}, 32'd0);
      chk("glitch_counter", ctr, 32'd5);
      chk("glitch_sb_empty", sb.size(), 32'd0);

      // 5: illegal double-bit transitions
      drive(2'b00, 10);
      drive(2'b11, 10);
      chk("ill1_err", {31'd0, qif.err}, 32'd1);
      chk("ill1_cnt", {24'd0, qif.err_cnt}, 32'd1);
      drive(2'b00, LAT - 1);
      qif.err_clr = 1'b1;
      tick();
      qif.err_clr = 1'b0;
      chk("ill2_err_wins", {31'd0, qif.err}, 32'd1);
      chk("ill2_cnt", {24'd0, qif.err_cnt}, 32'd2);
      repeat (3) tick();
      qif.err_clr = 1'b1;
      tick();
      qif.err_clr = 1'b0;
      chk("clr_err", {31'd0, qif.err}, 32'd0);
      chk("clr_cnt_kept", {24'd0, qif.err_cnt}, 32'd2);
      drive(2'b01, 10);
      drive(2'b00, 10);
      for (int i = 0; i < 298; i++) drive(~ph, 8);
      repeat (4) tick();
      chk("sat_cnt", {24'd0, qif.err_cnt}, 32'd255);
      chk("sat_model", {24'd0, qif.err_cnt}, merr);
      chk("sat_err", {31'd0, qif.err}, 32'd1);

      // 6: reset one cycle after a legal edge drops the pending pulse
      drive(2'b01, 1);
      rst = 1'b1;
      tick();
      sb.delete();
      tick();
      chk_reset_vals("rst6");
      rst = 1'b0;
      merr = 0;
      repeat (LAT - 1) tick();
      chk("ready6_early", {31'd0, qif.ready}, 32'd0);
      tick();
      chk("ready6_settled", {31'd0, qif.ready}, 32'd1);
      chk("err6", {31'd0, qif.err}, 32'd0);
      ctr = 0;
      drive(2'b11, 10);
      chk("post_rst_counter", ctr, 32'd1);
      chk("final_sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
